// File: rtl/scoreboard_registers.sv
// Register file with combinational 2-read / 1-write ports, write-to-read bypass,
// a per-register busy scoreboard (reserve/release) and a multi-cycle clear sweep.
module scoreboard_registers #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic                  read_ready1,
  output logic                  read_ready2,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserve_reg,
  output logic                  reserve_ok,
  input  logic                  clear,
  output logic                  clearing
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IdxLast = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q, busy_d;

  logic bypass1, bypass2;
  logic zero1, zero2, zero_wr, zero_res;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign clearing = (state_q == StClear);

  assign zero1    = is_zero(read_reg1);
  assign zero2    = is_zero(read_reg2);
  assign zero_wr  = is_zero(write_reg);
  assign zero_res = is_zero(reserve_reg);

  assign bypass1 = write && (write_reg == read_reg1) && !clearing && !zero1;
  assign bypass2 = write && (write_reg == read_reg2) && !clearing && !zero2;

  always_comb begin
    read_data1 = regs_q[read_reg1];
    if (zero1) begin
      read_data1 = '0;
    end else if (bypass1) begin
      read_data1 = write_data;
    end
  end

  always_comb begin
    read_data2 = regs_q[read_reg2];
    if (zero2) begin
      read_data2 = '0;
    end else if (bypass2) begin
      read_data2 = write_data;
    end
  end

  // Register 0 (when hardwired) is never busy, so it reads as ready outside a sweep.
  assign read_ready1 = !clearing && (!busy_q[read_reg1] || bypass1);
  assign read_ready2 = !clearing && (!busy_q[read_reg2] || bypass2);

  // A same-cycle write to the reserved index releases it, so the reservation may proceed.
  assign reserve_ok = !clearing && reserve &&
                      (!busy_q[reserve_reg] || (write && (write_reg == reserve_reg)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          // Clear has priority: the same-cycle write and reserve are dropped.
          state_d = StClear;
          idx_d   = '0;
          busy_d  = '0;
        end else begin
          if (write && !zero_wr) begin
            regs_d[write_reg] = write_data;
            busy_d[write_reg] = 1'b0;
          end
          // Applied after the write so a same-index reservation wins.
          if (reserve_ok && !zero_res) begin
            busy_d[reserve_reg] = 1'b1;
          end
        end
      end
      StClear: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == IdxLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_registers.sv
// Directed bench for scoreboard_registers: behavioural model checked every cycle,
// plus hand-computed literal expectations along the test-plan sequence.
module tb_scoreboard_registers;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic [AW-1:0] read_reg1, read_reg2;
  logic [DW-1:0] read_data1, read_data2;
  logic          read_ready1, read_ready2;
  logic          write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          reserve;
  logic [AW-1:0] reserve_reg;
  logic          reserve_ok;
  logic          clear;
  logic          clearing;

  int n_total = 0;
  int n_pass  = 0;

  scoreboard_registers #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ZERO_REG  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .read_ready1(read_ready1),
    .read_ready2(read_ready2),
    .write      (write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reserve    (reserve),
    .reserve_reg(reserve_reg),
    .reserve_ok (reserve_ok),
    .clear      (clear),
    .clearing   (clearing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_reg  [DEPTH];
  bit m_busy [DEPTH];
  int clear_left = 0;  // sweep cycles still to run; nonzero means clearing

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = 0;
      m_busy[i] = 0;
    end
  end

  function automatic bit m_clearing();
    return clear_left > 0;
  endfunction

  function automatic int exp_data(input int r);
    if (r == 0) return 0;
    if (!m_clearing() && write && (int'(write_reg) == r)) return int'(write_data);
    return m_reg[r];
  endfunction

  function automatic bit exp_ready(input int r);
    if (m_clearing()) return 0;
    if (r == 0) return 1;
    return !m_busy[r] || (write && (int'(write_reg) == r));
  endfunction

  function automatic bit exp_ok();
    int r;
    r = int'(reserve_reg);
    return !m_clearing() && reserve && (!m_busy[r] || (write && (int'(write_reg) == r)));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = 0;
        m_busy[i] = 0;
      end
      clear_left = 0;
    end else if (clear_left > 0) begin
      m_reg[DEPTH - clear_left] = 0;
      clear_left = clear_left - 1;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      clear_left = DEPTH;
    end else begin
      bit ok;
      ok = exp_ok();
      if (write && write_reg != 0) begin
        m_reg[write_reg]  = int'(write_data);
        m_busy[write_reg] = 0;
      end
      if (ok && reserve_reg != 0) m_busy[reserve_reg] = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model comparison on every falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("model read_data1", int'(read_data1), exp_data(int'(read_reg1)));
    chk("model read_data2", int'(read_data2), exp_data(int'(read_reg2)));
    chk("model read_ready1", int'(read_ready1), int'(exp_ready(int'(read_reg1))));
    chk("model read_ready2", int'(read_ready2), int'(exp_ready(int'(read_reg2))));
    chk("model reserve_ok", int'(reserve_ok), int'(exp_ok()));
    chk("model clearing", int'(clearing), int'(m_clearing()));
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    write = 0; write_reg = 0; write_data = 0;
    reserve = 0; reserve_reg = 0; clear = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [AW-1:0] r, input logic [DW-1:0] d);
    write = 1; write_reg = r; write_data = d;
  endtask

  task automatic rsv(input logic [AW-1:0] r);
    reserve = 1; reserve_reg = r;
  endtask

  initial begin
    reset = 0;
    read_reg1 = 0; read_reg2 = 0;
    idle();
    #2;
    read_reg1 = 2; read_reg2 = 3; rsv(1);
    #1;
    chk("reset read_data1", int'(read_data1), 0);
    chk("reset read_ready2", int'(read_ready2), 1);
    chk("reset clearing", int'(clearing), 0);
    chk("reset reserve_ok", int'(reserve_ok), 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    idle();

    // Bypass then storage
    read_reg1 = 2; wr(2, 8'h55);
    #2 chk("bypass data1", int'(read_data1), 'h55);
    next();
    #2 chk("stored data1", int'(read_data1), 'h55);

    // Reserve / refuse / release
    rsv(3); read_reg2 = 3;
    #2 chk("first reserve ok", int'(reserve_ok), 1);
    next();
    rsv(3);
    #2;
    chk("busy ready2", int'(read_ready2), 0);
    chk("second reserve refused", int'(reserve_ok), 0);
    next();
    wr(3, 8'hCC);
    #2;
    chk("release ready2", int'(read_ready2), 1);
    chk("release data2", int'(read_data2), 'hCC);
    next();

    // Same-cycle write and reserve: reservation wins
    wr(1, 8'h11); rsv(1); read_reg1 = 1;
    #2 chk("wr+rsv ok", int'(reserve_ok), 1);
    next();
    #2;
    chk("wr+rsv busy ready1", int'(read_ready1), 0);
    chk("wr+rsv data1", int'(read_data1), 'h11);

    // Hardwired zero register
    next();
    wr(0, 8'hFF); read_reg1 = 0;
    #2 chk("zero no bypass", int'(read_data1), 0);
    next();
    rsv(0);
    #2;
    chk("zero read", int'(read_data1), 0);
    chk("zero ready", int'(read_ready1), 1);
    chk("zero reserve ok", int'(reserve_ok), 1);
    next();
    #2 chk("zero not busy", int'(read_ready1), 1);

    // Load, reserve, then clear with a dropped write
    next();
    wr(1, 8'hA1); next();
    wr(2, 8'hA2); next();
    wr(3, 8'hA3); next();
    rsv(2); next();
    read_reg1 = 1; read_reg2 = 2;
    #2 chk("pre-clear busy reg2", int'(read_ready2), 0);
    next();
    clear = 1; wr(1, 8'h77);
    #2 chk("clear cycle not clearing", int'(clearing), 0);
    for (int c = 0; c < DEPTH; c++) begin
      next();
      #2;
      chk("sweep clearing", int'(clearing), 1);
      chk("sweep ready1", int'(read_ready1), 0);
    end
    next();
    #2;
    chk("post clearing", int'(clearing), 0);
    chk("post reg1", int'(read_data1), 0);
    chk("post reg2 ready", int'(read_ready2), 1);
    read_reg2 = 3;
    #1 chk("post reg3", int'(read_data2), 0);

    // Reset aborts sweep
    next();
    wr(1, 8'h5A); next();
    rsv(3); next();
    clear = 1; next();
    next();
    chk("2nd sweep cycle", int'(clearing), 1);
    reset = 0;
    #1;
    chk("abort clearing", int'(clearing), 0);
    chk("abort reg1", int'(read_data1), 0);
    chk("abort reg3 ready", int'(read_ready2), 1);
    @(posedge clk);
    #1;
    reset = 1;
    wr(1, 8'h3C);
    next();
    #2 chk("after reset write", int'(read_data1), 'h3C);
    next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
